// File: rtl/cache_ctrl.sv
// cache_ctrl: 4-line fully-associative write-back cache controller with LRU replacement and RAM write-back/refill sequencing.
module cache_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_hit,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack,
    output logic [3:0]        wrenCache,
    output logic              wrenRam,
    output logic [3:0]        valid_o,
    output logic [3:0]        dirty_o
);
    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESP} state_t;
    state_t state, state_n;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic [ADDR_W-1:0] tag [4];
    logic [DATA_W-1:0] data [4];
    logic [1:0]        age [4];
    logic [1:0]        v, vict, hit_idx, acc_idx;
    logic              hit, acc;
    always_comb begin
        state_n = state;
        hit     = 1'b0;
        hit_idx = 2'd0;
        vict    = 2'd0;
        for (int i = 3; i >= 0; i--) if (age[i] == 2'd3) vict = 2'(i);
        for (int i = 3; i >= 0; i--) if (!valid_o[i]) vict = 2'(i);
        for (int i = 0; i < 4; i++) if (valid_o[i] && tag[i] == a_addr) begin
            hit     = 1'b1;
            hit_idx = 2'(i);
        end
        acc     = (state == LOOKUP && hit) || (state == REFILL && ram_ack);
        acc_idx = state == LOOKUP ? hit_idx : v;
        case (state)
            IDLE:      state_n = req_valid && req_ready ? LOOKUP : IDLE;
            LOOKUP:    state_n = hit ? RESP : (valid_o[vict] && dirty_o[vict]) ? WRITEBACK : REFILL;
            WRITEBACK: state_n = ram_ack ? REFILL : WRITEBACK;
            REFILL:    state_n = ram_ack ? RESP : REFILL;
            default:   state_n = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_hit   <= 1'b0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            wrenCache  <= '0;
            wrenRam    <= 1'b0;
            valid_o    <= '0;
            dirty_o    <= '0;
            a_we       <= 1'b0;
            a_addr     <= '0;
            a_wdata    <= '0;
            v          <= '0;
            for (int i = 0; i < 4; i++) begin
                tag[i]  <= '0;
                data[i] <= '0;
                age[i]  <= 2'(i);
            end
        end else begin
            state      <= state_n;
            req_ready  <= state_n == IDLE;
            resp_valid <= state == RESP;
            ram_en     <= state_n == WRITEBACK || state_n == REFILL;
            ram_we     <= state_n == WRITEBACK;
            wrenCache  <= '0;
            wrenRam    <= state == WRITEBACK && ram_ack;
            if (state == IDLE && req_valid) begin
                a_we    <= req_we;
                a_addr  <= req_addr;
                a_wdata <= req_wdata;
            end
            if (state == LOOKUP) begin
                v         <= vict;
                ram_addr  <= state_n == WRITEBACK ? tag[vict] : a_addr;
                ram_wdata <= data[vict];
            end
            if (state == LOOKUP && hit) begin
                resp_hit   <= 1'b1;
                resp_rdata <= a_we ? a_wdata : data[hit_idx];
                if (a_we) begin
                    data[hit_idx]    <= a_wdata;
                    dirty_o[hit_idx] <= 1'b1;
                    wrenCache        <= 4'b1 << hit_idx;
                end
            end
            if (state == WRITEBACK && ram_ack) begin
                dirty_o[v] <= 1'b0;
                ram_addr   <= a_addr;
            end
            // a write miss merges its data into the refill in the same cycle
            if (state == REFILL && ram_ack) begin
                data[v]    <= a_we ? a_wdata : ram_rdata;
                tag[v]     <= a_addr;
                valid_o[v] <= 1'b1;
                dirty_o[v] <= a_we;
                wrenCache  <= 4'b1 << v;
                resp_rdata <= a_we ? a_wdata : ram_rdata;
                resp_hit   <= 1'b0;
            end
            if (acc)
                for (int i = 0; i < 4; i++)
                    age[i] <= 2'(i) == acc_idx ? 2'd0 : age[i] < age[acc_idx] ? age[i] + 2'd1 : age[i];
        end
    end
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: scoreboard bench for cache_ctrl with a latency-configurable RAM responder.
module tb_cache_ctrl;
    logic       clock = 0, resetn = 0, req_valid = 0, req_we = 0;
    logic [7:0] req_addr = 0, req_wdata = 0, ram_rdata = 0;
    logic       ack_r = 0, ack_f = 0, ram_ack;
    logic       req_ready, resp_valid, resp_hit, ram_en, ram_we, wrenRam;
    logic [7:0] resp_rdata, ram_addr, ram_wdata;
    logic [3:0] wrenCache, valid_o, dirty_o;
    assign ram_ack = ack_r | ack_f;
    cache_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
        .clock(clock), .resetn(resetn), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ack(ram_ack), .wrenCache(wrenCache), .wrenRam(wrenRam),
        .valid_o(valid_o), .dirty_o(dirty_o)
    );
    always #5 clock = ~clock;
    typedef struct packed { logic [7:0] rdata; logic hit; } exp_t;
    exp_t       exp_q[$];
    exp_t       e;
    int         pass_n = 0, total_n = 0, ram_lat = 2, cnt = 0, lat;
    logic [7:0] mem [256];
    logic [3:0] wren_or;
    int         wrenram_n;
    logic       ram_seen, wb_seen, pulse_one, got_hit;
    logic [7:0] wb_addr, wb_data, rf_addr, got_rdata;
    // RAM model: acks ram_lat cycles into each transaction, one-cycle ack
    always @(negedge clock) begin
        logic was;
        was = ack_r;
        ack_r = 0;
        if (!ram_en) cnt = 0;
        else begin
            cnt = was ? 1 : cnt + 1;
            if (cnt >= ram_lat) begin
                ack_r = 1;
                ram_rdata = mem[ram_addr];
                if (ram_we) mem[ram_addr] = ram_wdata;
            end
        end
    end
    task automatic do_req(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        int n;
        wren_or = 0; wrenram_n = 0; ram_seen = 0; wb_seen = 0; wb_addr = 0; wb_data = 0; rf_addr = 0; lat = 0;
        @(negedge clock);
        req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clock); n++; end
        if (!req_ready) begin total_n++; $display("FAIL accept_timeout addr=%h req_ready=%b need 1", addr, req_ready); end
        @(posedge clock);
        #1 req_valid = 0;
        while (!resp_valid && lat < 200) begin
            @(negedge clock);
            lat++;
            wren_or |= wrenCache;
            wrenram_n += int'(wrenRam);
            ram_seen |= ram_en;
            if (ram_en && ram_we) begin wb_seen = 1; wb_addr = ram_addr; wb_data = ram_wdata; end
            if (ram_en && !ram_we) rf_addr = ram_addr;
        end
        if (!resp_valid) begin total_n++; $display("FAIL resp_timeout addr=%h resp_valid=%b need 1", addr, resp_valid); end
        got_rdata = resp_rdata;
        got_hit = resp_hit;
        @(negedge clock);
        pulse_one = !resp_valid;
    endtask
    task automatic test_reset();
        resetn = 0;
        repeat (3) @(negedge clock);
        total_n++;
        if ({req_ready, resp_valid, resp_hit, ram_en, ram_we, wrenRam, wrenCache, valid_o, dirty_o} !== 18'h20000)
            $display("FAIL reset_ctrl got %b need 100000 0000 0000 0000", {req_ready, resp_valid, resp_hit, ram_en, ram_we, wrenRam, wrenCache, valid_o, dirty_o});
        else pass_n++;
        total_n++;
        if ({resp_rdata, ram_addr, ram_wdata} !== 24'h0) $display("FAIL reset_data got %h need 000000", {resp_rdata, ram_addr, ram_wdata});
        else pass_n++;
        resetn = 1;
    endtask
    task automatic test_read_miss();
        exp_q.push_back('{mem[8'h10], 1'b0});
        do_req(0, 8'h10, 0);
        e = exp_q.pop_front();
        total_n++; if (got_rdata !== e.rdata) $display("FAIL miss_rdata got %h need %h", got_rdata, e.rdata); else pass_n++;
        total_n++; if (got_hit !== e.hit) $display("FAIL miss_hit got %b need %b", got_hit, e.hit); else pass_n++;
        total_n++; if (wb_seen !== 1'b0) $display("FAIL miss_no_wb got %b need 0", wb_seen); else pass_n++;
        total_n++; if (rf_addr !== 8'h10) $display("FAIL miss_ram_addr got %h need 10", rf_addr); else pass_n++;
        total_n++; if (wren_or !== 4'b0001) $display("FAIL miss_wren got %b need 0001", wren_or); else pass_n++;
        total_n++; if ({valid_o, dirty_o} !== 8'b0001_0000) $display("FAIL miss_vd got %b need 00010000", {valid_o, dirty_o}); else pass_n++;
    endtask
    task automatic test_read_hit();
        exp_q.push_back('{8'hA5, 1'b1});
        do_req(0, 8'h10, 0);
        e = exp_q.pop_front();
        total_n++; if ({got_rdata, got_hit} !== {e.rdata, e.hit}) $display("FAIL hit_resp got %h/%b need %h/%b", got_rdata, got_hit, e.rdata, e.hit); else pass_n++;
        total_n++; if (lat !== 3) $display("FAIL hit_latency got %0d need 3", lat); else pass_n++;
        total_n++; if (ram_seen !== 1'b0) $display("FAIL hit_no_ram got %b need 0", ram_seen); else pass_n++;
        total_n++; if (pulse_one !== 1'b1) $display("FAIL hit_pulse_one got %b need 1", pulse_one); else pass_n++;
    endtask
    task automatic test_write_hit();
        exp_q.push_back('{8'h99, 1'b1});
        do_req(1, 8'h10, 8'h99);
        e = exp_q.pop_front();
        total_n++; if ({got_rdata, got_hit} !== {e.rdata, e.hit}) $display("FAIL whit1_resp got %h/%b need %h/%b", got_rdata, got_hit, e.rdata, e.hit); else pass_n++;
        exp_q.push_back('{8'h3C, 1'b1});
        do_req(1, 8'h10, 8'h3C);
        e = exp_q.pop_front();
        total_n++; if ({got_rdata, got_hit} !== {e.rdata, e.hit}) $display("FAIL whit2_resp got %h/%b need %h/%b", got_rdata, got_hit, e.rdata, e.hit); else pass_n++;
        total_n++; if (wren_or !== 4'b0001) $display("FAIL whit_wren got %b need 0001", wren_or); else pass_n++;
        total_n++; if (dirty_o !== 4'b0001) $display("FAIL whit_dirty got %b need 0001", dirty_o); else pass_n++;
        total_n++; if (ram_seen !== 1'b0) $display("FAIL whit_no_ram got %b need 0", ram_seen); else pass_n++;
    endtask
    task automatic test_evict();
        logic [7:0] a;
        for (int i = 2; i <= 4; i++) begin
            a = 8'(i * 16);
            exp_q.push_back('{mem[a], 1'b0});
            do_req(0, a, 0);
            e = exp_q.pop_front();
            total_n++; if ({got_rdata, got_hit} !== {e.rdata, e.hit}) $display("FAIL fill_resp addr=%h got %h/%b need %h/%b", a, got_rdata, got_hit, e.rdata, e.hit); else pass_n++;
        end
        exp_q.push_back('{mem[8'h50], 1'b0});
        do_req(0, 8'h50, 0);
        e = exp_q.pop_front();
        total_n++; if ({got_rdata, got_hit} !== {e.rdata, e.hit}) $display("FAIL evict_resp got %h/%b need %h/%b", got_rdata, got_hit, e.rdata, e.hit); else pass_n++;
        total_n++; if ({wb_seen, wb_addr, wb_data} !== {1'b1, 8'h10, 8'h3C}) $display("FAIL evict_wb got %b/%h/%h need 1/10/3c", wb_seen, wb_addr, wb_data); else pass_n++;
        total_n++; if (wrenram_n !== 1) $display("FAIL evict_wrenram got %0d need 1", wrenram_n); else pass_n++;
        total_n++; if (rf_addr !== 8'h50) $display("FAIL evict_refill_addr got %h need 50", rf_addr); else pass_n++;
        total_n++; if (wren_or !== 4'b0001) $display("FAIL evict_wren got %b need 0001", wren_or); else pass_n++;
        total_n++; if ({valid_o, dirty_o} !== 8'b1111_0000) $display("FAIL evict_vd got %b need 11110000", {valid_o, dirty_o}); else pass_n++;
        exp_q.push_back('{8'h3C, 1'b0});
        do_req(0, 8'h10, 0);
        e = exp_q.pop_front();
        total_n++; if ({got_rdata, got_hit} !== {e.rdata, e.hit}) $display("FAIL reread_resp got %h/%b need %h/%b", got_rdata, got_hit, e.rdata, e.hit); else pass_n++;
        total_n++; if ({wb_seen, wren_or} !== 5'b0_0010) $display("FAIL reread_lru got %b need 00010", {wb_seen, wren_or}); else pass_n++;
    endtask
    task automatic test_ack_first_cycle();
        ram_lat = 1;
        exp_q.push_back('{mem[8'h70], 1'b0});
        do_req(0, 8'h70, 0);
        e = exp_q.pop_front();
        total_n++; if ({got_rdata, got_hit} !== {e.rdata, e.hit}) $display("FAIL ack1_resp got %h/%b need %h/%b", got_rdata, got_hit, e.rdata, e.hit); else pass_n++;
        total_n++; if (wren_or !== 4'b0100) $display("FAIL ack1_lru_victim got %b need 0100", wren_or); else pass_n++;
        ram_lat = 2;
    endtask
    task automatic test_reset_mid_refill();
        int n;
        logic bad;
        ram_lat = 1000;
        @(negedge clock);
        req_valid = 1; req_we = 0; req_addr = 8'h80;
        @(negedge clock);
        req_valid = 0;
        n = 0;
        while (!ram_en && n < 20) begin @(negedge clock); n++; end
        total_n++; if ({ram_en, ram_we} !== 2'b10) $display("FAIL rst_refill_start got %b need 10", {ram_en, ram_we}); else pass_n++;
        resetn = 0;
        @(negedge clock);
        resetn = 1;
        total_n++; if ({ram_en, req_ready, valid_o} !== 6'b01_0000) $display("FAIL rst_abort got %b need 010000", {ram_en, req_ready, valid_o}); else pass_n++;
        ack_f = 1;
        @(negedge clock);
        ack_f = 0;
        bad = 0;
        repeat (3) begin
            @(negedge clock);
            bad |= ram_en | resp_valid | wrenRam | (|wrenCache) | (|valid_o) | !req_ready;
        end
        total_n++; if (bad !== 1'b0) $display("FAIL rst_stray_ack got %b need 0", bad); else pass_n++;
        ram_lat = 2;
    endtask
    task automatic test_write_miss();
        exp_q.push_back('{8'h77, 1'b0});
        do_req(1, 8'h60, 8'h77);
        e = exp_q.pop_front();
        total_n++; if ({got_rdata, got_hit} !== {e.rdata, e.hit}) $display("FAIL wmiss_resp got %h/%b need %h/%b", got_rdata, got_hit, e.rdata, e.hit); else pass_n++;
        total_n++; if ({wb_seen, wren_or} !== 5'b0_0001) $display("FAIL wmiss_wren got %b need 00001", {wb_seen, wren_or}); else pass_n++;
        total_n++; if ({valid_o, dirty_o} !== 8'b0001_0001) $display("FAIL wmiss_vd got %b need 00010001", {valid_o, dirty_o}); else pass_n++;
    endtask
    task automatic test_back_to_back();
        int n;
        exp_q.push_back('{8'h77, 1'b1});
        exp_q.push_back('{mem[8'h10], 1'b0});
        @(negedge clock);
        req_valid = 1; req_we = 0; req_addr = 8'h60;
        @(posedge clock);
        #1 req_addr = 8'h10;
        n = 0;
        while (!resp_valid && n < 50) begin @(negedge clock); n++; end
        e = exp_q.pop_front();
        total_n++; if ({resp_valid, resp_rdata, resp_hit} !== {1'b1, e.rdata, e.hit}) $display("FAIL b2b_first got %b/%h/%b need 1/%h/%b", resp_valid, resp_rdata, resp_hit, e.rdata, e.hit); else pass_n++;
        total_n++; if (req_ready !== 1'b1) $display("FAIL b2b_ready got %b need 1", req_ready); else pass_n++;
        @(posedge clock);
        #1 req_valid = 0;
        @(negedge clock);
        total_n++; if (req_ready !== 1'b0) $display("FAIL b2b_accept got %b need 0", req_ready); else pass_n++;
        n = 0;
        while (!resp_valid && n < 50) begin @(negedge clock); n++; end
        e = exp_q.pop_front();
        total_n++; if ({resp_valid, resp_rdata, resp_hit} !== {1'b1, e.rdata, e.hit}) $display("FAIL b2b_second got %b/%h/%b need 1/%h/%b", resp_valid, resp_rdata, resp_hit, e.rdata, e.hit); else pass_n++;
        @(negedge clock);
    endtask
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h10] = 8'hA5;
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_hit();
        test_evict();
        test_ack_first_cycle();
        test_reset_mid_refill();
        test_write_miss();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
Controller for the 4-line, fully-associative, write-back data cache. It accepts single CPU read/write requests and keeps tag, valid, dirty and LRU state for every line. On a miss it sequences the victim write-back to RAM and the line refill, then completes the request. It drives the per-line cache write enables and the RAM write strobe, and exports valid/dirty state for debug.

Parameters:
ADDR_W, 8, address width; the full address is the tag (one word per line, fully associative)
DATA_W, 8, data word width

Ports:
clock  input  1  system clock, all logic on rising edge
resetn  input  1  synchronous, active-low reset
req_valid  input  1  CPU request present
req_we  input  1  1=write, 0=read
req_addr  input  ADDR_W  request address
req_wdata  input  DATA_W  write data
req_ready  output  1  controller idle; request accepted when req_valid&req_ready
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  DATA_W  read data (for writes: the written data)
resp_hit  output  1  qualifies resp_valid; 1=hit, 0=miss serviced
ram_en  output  1  RAM transaction active; held until ram_ack
ram_we  output  1  1=write-back, 0=refill read
ram_addr  output  ADDR_W  RAM address
ram_wdata  output  DATA_W  write-back data
ram_rdata  input  DATA_W  refill data, valid with ram_ack
ram_ack  input  1  RAM completes the current transaction (any latency ≥1 cycle)
wrenCache  output  4  one-hot pulse: cache line i data written this cycle
wrenRam  output  1  pulse: write-back accepted by RAM this cycle
valid_o  output  4  line valid bits
dirty_o  output  4  line dirty bits

Behaviour:
- Reset (resetn=0 at an edge): state IDLE; valid=0000, dirty=0000, tags=0, data=0; LRU ages line0..3 = 0,1,2,3; req_ready=1; every other output 0. Reset overrides any in-flight transaction. ram_en drops at that edge, and a later ram_ack is ignored.
- All outputs are registered.
- States:
  - IDLE: req_ready=1. On accept, latch we/addr/wdata and go to LOOKUP; req_ready=0 from the next cycle.
  - LOOKUP: compare the latched address with all valid tags.
    - Hit on line h: read returns data[h]. Write sets data[h]=wdata, dirty[h]=1 and pulses wrenCache[h]. Go to RESP with resp_hit=1.
    - Miss: victim = lowest-index invalid line, else the line with age 3. If the victim is valid and dirty, go to WRITEBACK, else go to REFILL.
  - WRITEBACK: ram_en=1, ram_we=1, ram_addr=victim tag, ram_wdata=victim data, held stable. On ram_ack: wrenRam pulse, dirty[v]=0, go to REFILL.
  - REFILL: ram_en=1, ram_we=0, ram_addr=request addr. On ram_ack: data[v]=ram_rdata, tag[v]=addr, valid[v]=1, wrenCache[v] pulse.
    - Write request: the same cycle stores wdata instead of ram_rdata and sets dirty[v]=1.
    - Read request: dirty[v]=0.
    - Go to RESP with resp_hit=0.
  - RESP: resp_valid=1 for exactly one cycle with resp_rdata/resp_hit. No backpressure. Return to IDLE (req_ready=1 the next cycle).
- Latency: request accepted at edge T; a hit gives resp_valid in the cycle after edge T+2. A miss adds RAM latency per transaction plus one cycle per state.
- LRU update on every completed access to line i with age a: lines with age < a increment, line i's age becomes 0. Ages remain a permutation of 0..3.
- ram_ack while ram_en=0 is ignored.
- ram_ack in the first cycle of WRITEBACK/REFILL is legal and completes that transaction.
- A write hit to an already-dirty line keeps dirty=1 and generates no RAM traffic.
- Back-to-back requests: a request held on req_valid during a busy period is accepted in the first IDLE cycle.

Test Plan:
- After reset, read 0x10; RAM acks with 0xA5 two cycles after ram_en rises -> no WRITEBACK; ram_addr=0x10, ram_we=0; wrenCache=0001 pulse; resp_rdata=0xA5, resp_hit=0; valid_o=0001, dirty_o=0000.
- Read 0x10 again -> resp_valid two cycles after accept, resp_hit=1, rdata=0xA5, ram_en never asserted, LRU unchanged.
- Write 0x3C to 0x10 -> hit; wrenCache=0001; dirty_o=0001; resp_hit=1; no RAM traffic.
- Read 0x20, 0x30, 0x40 (fill lines 1-3), then read 0x50 -> victim line0. WRITEBACK: ram_we=1, ram_addr=0x10, ram_wdata=0x3C, wrenRam pulse on ack. Then REFILL at 0x50; line0 tag=0x50, dirty_o=0000.
- Assert resetn=0 for one edge while REFILL waits for ack -> ram_en=0, req_ready=1, valid_o=0000 after the edge; ram_ack pulsed afterwards changes nothing.
- Write 0x77 to 0x60 with a clean LRU victim -> no WRITEBACK; REFILL then merge; victim dirty=1, data=0x77, resp_rdata=0x77, resp_hit=0.
